wb_commit_ctrl: RTL
===================

// Module: wb_commit_ctrl
// PURPOSE
//  WB-stage commit controller; the requesting side of the csr block's write/exception port.
//  Latches one retiring instruction from MEM and drives csr_re/num/we/wmask/wvalue.
//  Raises wb_ex (with ecode, esubcode, vaddr, pc) or ertn_flush, performs the regfile write,
//  and issues a pipeline flush with redirect PC from ex_entry/ertn_entry.
//  Counts retired instructions.
// PARAMETERS
//  DRAIN_CYCLES  2  cycles after a flush during which MEM->WB transfers are discarded (>=1)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high reset
//  ms_to_ws_valid in   1   MEM holds a valid instruction for WB
//  ws_allowin     out  1   WB accepts a transfer this cycle
//  ms_pc          in   32  instruction PC
//  ms_vaddr       in   32  memory access address (for BADV)
//  ms_ex          in   1   instruction carries an exception
//  ms_ecode       in   6   exception code
//  ms_esubcode    in   9   exception subcode
//  ms_ertn        in   1   instruction is ertn
//  ms_csr_re      in   1   instruction reads a CSR (csrrd/csrwr/csrxchg)
//  ms_csr_we      in   1   instruction writes a CSR
//  ms_csr_num     in   14  CSR number
//  ms_csr_wmask   in   32  CSR write mask
//  ms_csr_wvalue  in   32  CSR write value
//  ms_rf_we       in   1   regfile write enable
//  ms_rf_waddr    in   5   regfile destination
//  ms_rf_wdata    in   32  regfile data (non-CSR result)
//  csr_rvalue     in   32  CSR read data (combinational from csr)
//  ex_entry       in   32  exception entry from csr
//  ertn_entry     in   32  ertn return address from csr
//  csr_re/csr_num/csr_we/csr_wmask/csr_wvalue  out 1/14/1/32/32  CSR access port
//  wb_ex/wb_ecode/wb_esubcode/wb_vaddr/wb_pc   out 1/6/9/32/32   exception report
//  ertn_flush     out  1   ertn commit
//  rf_we/rf_waddr/rf_wdata                     out 1/5/32        regfile write
//  ws_flush       out  1   flush all earlier stages this cycle
//  flush_pc       out  32  redirect target, valid with ws_flush
//  instret        out  64  count of retired (non-excepting) instructions
// BEHAVIOUR
//  - Registers: ws_valid, the latched ms_* fields, state {RUN, DRAIN}, drain_cnt, instret.
//  - Reset: ws_valid=0, state=RUN, drain_cnt=0, instret=0.
//    All 1-bit outputs are 0 during and immediately after reset; flush_pc=ertn_entry.
//  - Latency: WB always completes in one cycle (ready_go=1).
//  - ws_allowin=1 in both states; stall is never required.
//  - RUN: if ms_to_ws_valid then ws_valid<=1 and all fields load, else ws_valid<=0.
//  - DRAIN: ws_valid<=0; incoming transfers are accepted and dropped.
//    drain_cnt decrements; at 1 -> RUN.
//  - Every cycle ws_valid=1 and (wb_ex|ertn_flush): state<=DRAIN, drain_cnt<=DRAIN_CYCLES,
//    and the same-cycle ms transfer is dropped.
//  - Outputs (combinational from WB regs):
//    - wb_ex=ws_valid&ex.
//    - ertn_flush=ws_valid&ertn&~ex.
//    - csr_re=ws_valid&csr_re&~ex.
//    - csr_we=ws_valid&csr_we&~ex.
//    - rf_we=ws_valid&rf_we&~ex.
//    - rf_wdata = csr_re ? csr_rvalue : rf_wdata.
//    - csr_num/wmask/wvalue/wb_ecode/esubcode/vaddr/wb_pc are passed through unconditionally.
//  - ws_flush=wb_ex|ertn_flush; flush_pc = wb_ex ? ex_entry : ertn_entry.
//  - Exception has priority over ertn, CSR write and regfile write of the same instruction.
//  - csrwr read+write same cycle: rf_wdata is the OLD CSR value (csr updates at the clock edge).
//  - instret += 1 when ws_valid&~ex (ertn counts).
//    64-bit wrap from all-ones to 0 is required; no saturation.
//  - Reset mid-DRAIN or mid-commit: immediate return to reset state.
//    No csr/rf write is issued in the reset cycle.
// TESTING
//  - Reset then csrwr num=0x30 wmask=FFFFFFFF wvalue=0x1234, csr_rvalue=0xAA:
//    next cycle csr_we=1, rf_we=1, rf_wdata=0xAA, instret=0->1.
//  - ms_ex=1 ecode=0x08 pc=0x1C000100 with csr_we/rf_we=1:
//    wb_ex=1, wb_pc=0x1C000100, csr_we=0, rf_we=0, ws_flush=1, flush_pc=ex_entry, instret unchanged.
//  - Back-to-back valid after an ertn, DRAIN_CYCLES=2: ertn_flush=1, flush_pc=ertn_entry.
//    The next 3 transfers (flush cycle + 2 DRAIN) are dropped; the 4th commits.
//  - ms_ex=1 and ms_ertn=1 together -> wb_ex=1, ertn_flush=0, flush_pc=ex_entry.
//  - Assert reset in the first DRAIN cycle -> ws_valid=0, state=RUN.
//    The next valid transfer commits in the following cycle.
//  - Force instret=64'hFFFF_FFFF_FFFF_FFFF, retire one -> instret=0.

Source files
------------

// File: rtl/wb_commit_ctrl.sv
// WB-stage commit controller: latches one retiring instruction, drives the csr write/exception
// port and the regfile write, issues flush/redirect and counts retired instructions.
module wb_commit_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_vaddr,
    input  logic        ms_ex,
    input  logic [5:0]  ms_ecode,
    input  logic [8:0]  ms_esubcode,
    input  logic        ms_ertn,
    input  logic        ms_csr_re,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    input  logic [31:0] csr_rvalue,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        csr_re,
    output logic [13:0] csr_num,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_vaddr,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        ws_flush,
    output logic [31:0] flush_pc,
    output logic [63:0] instret
);

    localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [0:0] StRun   = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic            ws_valid_q, ws_valid_d;
    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
    logic [63:0]     instret_q, instret_d;

    logic [31:0] pc_q;
    logic [31:0] vaddr_q;
    logic        ex_q;
    logic [5:0]  ecode_q;
    logic [8:0]  esubcode_q;
    logic        ertn_q;
    logic        csr_re_q;
    logic        csr_we_q;
    logic [13:0] csr_num_q;
    logic [31:0] csr_wmask_q;
    logic [31:0] csr_wvalue_q;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    logic ws_live;
    logic accept;

    // Gating with reset keeps a commit that is in flight from writing csr/rf in the reset cycle.
    assign ws_live    = ws_valid_q & ~reset;
    assign ws_allowin = ~reset;

    assign wb_ex      = ws_live & ex_q;
    assign ertn_flush = ws_live & ertn_q & ~ex_q;
    assign csr_re     = ws_live & csr_re_q & ~ex_q;
    assign csr_we     = ws_live & csr_we_q & ~ex_q;
    assign rf_we      = ws_live & rf_we_q & ~ex_q;

    assign csr_num     = csr_num_q;
    assign csr_wmask   = csr_wmask_q;
    assign csr_wvalue  = csr_wvalue_q;
    assign wb_ecode    = ecode_q;
    assign wb_esubcode = esubcode_q;
    assign wb_vaddr    = vaddr_q;
    assign wb_pc       = pc_q;
    assign rf_waddr    = rf_waddr_q;

    // csr_rvalue is the pre-edge value, so csrwr/csrxchg return the old CSR contents.
    assign rf_wdata = csr_re ? csr_rvalue : rf_wdata_q;

    assign ws_flush = wb_ex | ertn_flush;
    assign flush_pc = wb_ex ? ex_entry : ertn_entry;
    assign instret  = instret_q;

    assign accept = ms_to_ws_valid & (state_q == StRun) & ~ws_flush;

    always_comb begin
        ws_valid_d  = accept;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        instret_d   = instret_q + {63'd0, ws_live & ~ex_q};
        if (ws_flush) begin
            state_d     = StDrain;
            drain_cnt_d = CntW'(DRAIN_CYCLES);
        end else if (state_q == StDrain) begin
            drain_cnt_d = drain_cnt_q - CntW'(1);
            if (drain_cnt_q <= CntW'(1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q   <= 1'b0;
            state_q      <= StRun;
            drain_cnt_q  <= '0;
            instret_q    <= '0;
            pc_q         <= '0;
            vaddr_q      <= '0;
            ex_q         <= 1'b0;
            ecode_q      <= '0;
            esubcode_q   <= '0;
            ertn_q       <= 1'b0;
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_num_q    <= '0;
            csr_wmask_q  <= '0;
            csr_wvalue_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            ws_valid_q  <= ws_valid_d;
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            instret_q   <= instret_d;
            if (accept) begin
                pc_q         <= ms_pc;
                vaddr_q      <= ms_vaddr;
                ex_q         <= ms_ex;
                ecode_q      <= ms_ecode;
                esubcode_q   <= ms_esubcode;
                ertn_q       <= ms_ertn;
                csr_re_q     <= ms_csr_re;
                csr_we_q     <= ms_csr_we;
                csr_num_q    <= ms_csr_num;
                csr_wmask_q  <= ms_csr_wmask;
                csr_wvalue_q <= ms_csr_wvalue;
                rf_we_q      <= ms_rf_we;
                rf_waddr_q   <= ms_rf_waddr;
                rf_wdata_q   <= ms_rf_wdata;
            end
        end
    end

endmodule
